// File: rtl/cycle_report_tx.sv
// Cycle-count reporter: sends a latched 32-bit count as 8 uppercase hex ASCII digits
// plus CR LF over a UART 8N1 line. One report per accepted start pulse.
module cycle_report_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] count_in,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TIMER_RELOAD = TW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LAST_BYTE    = 4'd9;

    typedef enum logic [2:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        STOP_BIT,
        DONE
    } state_t;

    state_t        state, state_next;
    logic [31:0]   shadow, shadow_next;
    logic [3:0]    byte_idx, byte_idx_next;
    logic [2:0]    bit_idx, bit_idx_next;
    logic [TW-1:0] timer, timer_next;
    logic [7:0]    shift, shift_next;
    logic          tx_next, busy_next, done_next;

    logic [31:0]   enc_src;
    logic [3:0]    enc_idx;
    logic [3:0]    enc_nib;
    logic [7:0]    enc_byte;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        logic [7:0] r;
        if (n < 4'd10) r = 8'h30 + {4'h0, n};
        else           r = 8'h37 + {4'h0, n};
        return r;
    endfunction

    // The shift register is loaded as START_BIT is entered; from IDLE the shadow
    // register is being written on the same edge, so encode straight from count_in.
    always_comb begin
        enc_src = shadow;
        enc_idx = byte_idx + 4'd1;
        if (state == IDLE) begin
            enc_src = count_in;
            enc_idx = 4'd0;
        end
        enc_nib = 4'h0;
        case (enc_idx[2:0])
            3'd0: enc_nib = enc_src[31:28];
            3'd1: enc_nib = enc_src[27:24];
            3'd2: enc_nib = enc_src[23:20];
            3'd3: enc_nib = enc_src[19:16];
            3'd4: enc_nib = enc_src[15:12];
            3'd5: enc_nib = enc_src[11:8];
            3'd6: enc_nib = enc_src[7:4];
            3'd7: enc_nib = enc_src[3:0];
            default: enc_nib = 4'h0;
        endcase
        if (enc_idx == 4'd8)      enc_byte = 8'h0D;
        else if (enc_idx == 4'd9) enc_byte = 8'h0A;
        else                      enc_byte = hex_ascii(enc_nib);
    end

    // Next-state and registered-output logic; tx/busy/done are registered so the
    // line never glitches between bytes or reports.
    always_comb begin
        state_next    = state;
        shadow_next   = shadow;
        byte_idx_next = byte_idx;
        bit_idx_next  = bit_idx;
        timer_next    = timer;
        shift_next    = shift;
        tx_next       = tx;
        busy_next     = busy;
        done_next     = 1'b0;

        case (state)
            IDLE: begin
                tx_next   = 1'b1;
                busy_next = 1'b0;
                if (start) begin
                    shadow_next   = count_in;
                    byte_idx_next = 4'd0;
                    shift_next    = enc_byte;
                    timer_next    = TIMER_RELOAD;
                    tx_next       = 1'b0;
                    busy_next     = 1'b1;
                    state_next    = START_BIT;
                end
            end

            START_BIT: begin
                if (timer == '0) begin
                    timer_next   = TIMER_RELOAD;
                    bit_idx_next = 3'd0;
                    tx_next      = shift[0];
                    shift_next   = {1'b0, shift[7:1]};
                    state_next   = DATA_BITS;
                end else begin
                    timer_next = timer - TW'(1);
                end
            end

            DATA_BITS: begin
                if (timer == '0) begin
                    timer_next = TIMER_RELOAD;
                    if (bit_idx == 3'd7) begin
                        tx_next    = 1'b1;
                        state_next = STOP_BIT;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                        tx_next      = shift[0];
                        shift_next   = {1'b0, shift[7:1]};
                    end
                end else begin
                    timer_next = timer - TW'(1);
                end
            end

            STOP_BIT: begin
                if (timer == '0) begin
                    if (byte_idx < LAST_BYTE) begin
                        byte_idx_next = byte_idx + 4'd1;
                        shift_next    = enc_byte;
                        timer_next    = TIMER_RELOAD;
                        tx_next       = 1'b0;
                        state_next    = START_BIT;
                    end else begin
                        tx_next    = 1'b1;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                        state_next = DONE;
                    end
                end else begin
                    timer_next = timer - TW'(1);
                end
            end

            DONE: begin
                tx_next    = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
            end

            default: begin
                tx_next    = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shadow   <= 32'h0;
            byte_idx <= 4'd0;
            bit_idx  <= 3'd0;
            timer    <= '0;
            shift    <= 8'h0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            shadow   <= shadow_next;
            byte_idx <= byte_idx_next;
            bit_idx  <= bit_idx_next;
            timer    <= timer_next;
            shift    <= shift_next;
            tx       <= tx_next;
            busy     <= busy_next;
            done     <= done_next;
        end
    end

endmodule

// File: tb/tb_cycle_report_tx.sv
// Directed bench for cycle_report_tx: records tx each cycle, decodes the 10-byte
// reports from that history and checks timing of busy/done against fixed values.
module tb_cycle_report_tx;

    localparam int CPB  = 4;
    localparam int HIST = 8192;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] count_in;
    logic        tx, busy, done;

    cycle_report_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .count_in (count_in),
        .tx       (tx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   busy_cycles = 0;
    int   done_pulses = 0;
    int   done_cyc = 0;
    bit   overlap = 1'b0;
    bit   idle_low = 1'b0;
    bit   timed_out;
    bit   frame_ok;
    logic hist [HIST];
    logic [7:0] rx [10];

    // Per-cycle monitor, sampled on the falling edge away from DUT updates.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (cyc < HIST) hist[cyc] = tx;
        if (busy === 1'b1) busy_cycles = busy_cycles + 1;
        if (done === 1'b1) begin
            done_pulses = done_pulses + 1;
            done_cyc    = cyc;
        end
        if (busy === 1'b1 && done === 1'b1) overlap = 1'b1;
        if (busy === 1'b0 && tx !== 1'b1) idle_low = 1'b1;
    end

    task automatic tick_n(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_cyc(input int c);
        int k;
        k = 0;
        while (cyc < c && k < 5000) begin
            @(negedge clk);
            #1;
            k++;
        end
    endtask

    task automatic wait_done(input int target, input int budget);
        int k;
        k = 0;
        timed_out = 1'b0;
        while (done_pulses < target && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (done_pulses < target) timed_out = 1'b1;
    endtask

    task automatic pulse_start(input logic [31:0] v, output int sref);
        @(posedge clk);
        #1 start = 1'b1;
        count_in = v;
        @(posedge clk);
        sref = cyc;
        #1 start = 1'b0;
    endtask

    // Rebuild the 10 bytes of a report whose first tx-low cycle is base+1.
    task automatic decode(input int base);
        int   b0;
        logic v;
        frame_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            b0 = base + 1 + 40 * i;
            rx[i] = 8'hxx;
            if (b0 + 39 >= HIST) begin
                frame_ok = 1'b0;
            end else begin
                for (int k = 0; k < 4; k++) if (hist[b0 + k] !== 1'b0) frame_ok = 1'b0;
                for (int j = 0; j < 8; j++) begin
                    v = hist[b0 + 4 + 4 * j];
                    for (int k = 0; k < 4; k++) if (hist[b0 + 4 + 4 * j + k] !== v) frame_ok = 1'b0;
                    rx[i][j] = v;
                end
                for (int k = 0; k < 4; k++) if (hist[b0 + 36 + k] !== 1'b1) frame_ok = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b0;
        count_in = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (tx !== 1'b1)   begin errors++; $display("[TB] FAIL reset_tx: got %b expected 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    endtask

    // start is raised in the very first cycle with rst low.
    task automatic test_basic;
        int sref, b0, d0;
        logic [79:0] exp_bytes;
        exp_bytes = 80'h30303030303139300D0A;
        @(posedge clk);
        #1 rst = 1'b0;
        start = 1'b1;
        count_in = 32'h00000190;
        @(posedge clk);
        sref = cyc;
        b0 = busy_cycles;
        d0 = done_pulses;
        #1 start = 1'b0;
        wait_done(d0 + 1, 600);
        checks++; if (timed_out) begin errors++; $display("[TB] FAIL t1_timeout: got no done expected done"); end
        checks++; if (done_cyc - sref !== 401) begin errors++; $display("[TB] FAIL t1_done_cycle: got %0d expected 401", done_cyc - sref); end
        tick_n(3);
        checks++; if (busy_cycles - b0 !== 400) begin errors++; $display("[TB] FAIL t1_busy_len: got %0d expected 400", busy_cycles - b0); end
        checks++; if (done_pulses - d0 !== 1) begin errors++; $display("[TB] FAIL t1_done_count: got %0d expected 1", done_pulses - d0); end
        decode(sref);
        checks++; if (!frame_ok) begin errors++; $display("[TB] FAIL t1_framing: got 0 expected 1"); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (rx[i] !== exp_bytes[79 - 8 * i -: 8]) begin
                errors++; $display("[TB] FAIL t1_byte%0d: got %h expected %h", i, rx[i], exp_bytes[79 - 8 * i -: 8]);
            end
        end
    endtask

    task automatic test_deadbeef;
        int sref, d0;
        logic [79:0] exp_bytes;
        logic [39:0] pat;
        exp_bytes = 80'h44454144424545460D0A;
        pat = 40'hF0F000F000;
        d0 = done_pulses;
        pulse_start(32'hDEADBEEF, sref);
        wait_done(d0 + 1, 600);
        checks++; if (timed_out) begin errors++; $display("[TB] FAIL t2_timeout: got no done expected done"); end
        for (int k = 1; k <= 40; k++) begin
            checks++;
            if (hist[sref + k] !== pat[k - 1]) begin
                errors++; $display("[TB] FAIL t2_bit_cycle%0d: got %b expected %b", k, hist[sref + k], pat[k - 1]);
            end
        end
        decode(sref);
        checks++; if (!frame_ok) begin errors++; $display("[TB] FAIL t2_framing: got 0 expected 1"); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (rx[i] !== exp_bytes[79 - 8 * i -: 8]) begin
                errors++; $display("[TB] FAIL t2_byte%0d: got %h expected %h", i, rx[i], exp_bytes[79 - 8 * i -: 8]);
            end
        end
    endtask

    task automatic test_ignore_start;
        int sref, b0, d0;
        logic [79:0] exp_bytes;
        exp_bytes = 80'h31323334353637380D0A;
        tick_n(2);
        b0 = busy_cycles;
        d0 = done_pulses;
        pulse_start(32'h12345678, sref);
        wait_cyc(sref + 49);
        @(posedge clk);
        #1 start = 1'b1;
        count_in = 32'hFFFFFFFF;
        @(posedge clk);
        #1 start = 1'b0;
        wait_cyc(sref + 59);
        @(posedge clk);
        #1 count_in = 32'hCAFEF00D;
        wait_done(d0 + 1, 600);
        checks++; if (timed_out) begin errors++; $display("[TB] FAIL t3_timeout: got no done expected done"); end
        tick_n(20);
        checks++; if (done_pulses - d0 !== 1) begin errors++; $display("[TB] FAIL t3_done_count: got %0d expected 1", done_pulses - d0); end
        checks++; if (busy_cycles - b0 !== 400) begin errors++; $display("[TB] FAIL t3_busy_len: got %0d expected 400", busy_cycles - b0); end
        decode(sref);
        checks++; if (!frame_ok) begin errors++; $display("[TB] FAIL t3_framing: got 0 expected 1"); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (rx[i] !== exp_bytes[79 - 8 * i -: 8]) begin
                errors++; $display("[TB] FAIL t3_byte%0d: got %h expected %h", i, rx[i], exp_bytes[79 - 8 * i -: 8]);
            end
        end
    endtask

    task automatic test_reset_midframe;
        int sref, b0, d0;
        logic [79:0] exp_bytes;
        exp_bytes = 80'h30303030303030300D0A;
        pulse_start(32'h87654321, sref);
        wait_cyc(sref + 134);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (tx !== 1'b1)   begin errors++; $display("[TB] FAIL t4_tx_after_rst: got %b expected 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL t4_busy_after_rst: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL t4_done_after_rst: got %b expected 0", done); end
        b0 = busy_cycles;
        d0 = done_pulses;
        tick_n(30);
        checks++; if (busy_cycles !== b0) begin errors++; $display("[TB] FAIL t4_stays_idle_busy: got %0d expected %0d", busy_cycles, b0); end
        checks++; if (done_pulses !== d0) begin errors++; $display("[TB] FAIL t4_stays_idle_done: got %0d expected %0d", done_pulses, d0); end
        checks++; if (tx !== 1'b1) begin errors++; $display("[TB] FAIL t4_stays_idle_tx: got %b expected 1", tx); end
        pulse_start(32'h00000000, sref);
        wait_done(d0 + 1, 600);
        checks++; if (timed_out) begin errors++; $display("[TB] FAIL t4_timeout: got no done expected done"); end
        decode(sref);
        checks++; if (!frame_ok) begin errors++; $display("[TB] FAIL t4_framing: got 0 expected 1"); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (rx[i] !== exp_bytes[79 - 8 * i -: 8]) begin
                errors++; $display("[TB] FAIL t4_byte%0d: got %h expected %h", i, rx[i], exp_bytes[79 - 8 * i -: 8]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int sref, sref2, d0, dcyc;
        logic [79:0] exp_bytes;
        exp_bytes = 80'h46464646464646460D0A;
        tick_n(2);
        d0 = done_pulses;
        pulse_start(32'h0000BEEF, sref);
        wait_done(d0 + 1, 600);
        checks++; if (timed_out) begin errors++; $display("[TB] FAIL t5_first_timeout: got no done expected done"); end
        dcyc = cyc;
        @(posedge clk);
        #1 start = 1'b1;
        count_in = 32'hFFFFFFFF;
        @(posedge clk);
        sref2 = cyc;
        #1 start = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (sref2 !== dcyc + 1) begin errors++; $display("[TB] FAIL t5_start_cycle: got %0d expected %0d", sref2, dcyc + 1); end
        checks++; if (tx !== 1'b0)   begin errors++; $display("[TB] FAIL t5_tx_low: got %b expected 0", tx); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL t5_busy: got %b expected 1", busy); end
        checks++; if (hist[dcyc] !== 1'b1 || hist[dcyc + 1] !== 1'b1) begin
            errors++; $display("[TB] FAIL t5_gap_tx: got %b%b expected 11", hist[dcyc], hist[dcyc + 1]);
        end
        wait_done(d0 + 2, 600);
        checks++; if (timed_out) begin errors++; $display("[TB] FAIL t5_second_timeout: got no done expected done"); end
        decode(sref2);
        checks++; if (!frame_ok) begin errors++; $display("[TB] FAIL t5_framing: got 0 expected 1"); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (rx[i] !== exp_bytes[79 - 8 * i -: 8]) begin
                errors++; $display("[TB] FAIL t5_byte%0d: got %h expected %h", i, rx[i], exp_bytes[79 - 8 * i -: 8]);
            end
        end
    endtask

    task automatic test_hold_start;
        int sref, b0, d0;
        logic [79:0] exp_bytes;
        exp_bytes = 80'h30303030303030410D0A;
        tick_n(2);
        b0 = busy_cycles;
        d0 = done_pulses;
        @(posedge clk);
        #1 start = 1'b1;
        count_in = 32'h0000000A;
        @(posedge clk);
        sref = cyc;
        repeat (999) @(posedge clk);
        #1 start = 1'b0;
        wait_done(d0 + 3, 2000);
        checks++; if (timed_out) begin errors++; $display("[TB] FAIL t6_timeout: got no done expected done"); end
        tick_n(10);
        checks++; if (done_pulses - d0 !== 3) begin errors++; $display("[TB] FAIL t6_done_count: got %0d expected 3", done_pulses - d0); end
        checks++; if (busy_cycles - b0 !== 1200) begin errors++; $display("[TB] FAIL t6_busy_len: got %0d expected 1200", busy_cycles - b0); end
        checks++; if (done_cyc - sref !== 1205) begin errors++; $display("[TB] FAIL t6_last_done: got %0d expected 1205", done_cyc - sref); end
        checks++; if (hist[sref + 402] !== 1'b1 || hist[sref + 403] !== 1'b0) begin
            errors++; $display("[TB] FAIL t6_gap: got %b%b expected 10", hist[sref + 402], hist[sref + 403]);
        end
        for (int r = 0; r < 3; r++) begin
            decode(sref + 402 * r);
            checks++; if (!frame_ok) begin errors++; $display("[TB] FAIL t6_framing_r%0d: got 0 expected 1", r); end
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (rx[i] !== exp_bytes[79 - 8 * i -: 8]) begin
                    errors++; $display("[TB] FAIL t6_r%0d_byte%0d: got %h expected %h", r, i, rx[i], exp_bytes[79 - 8 * i -: 8]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_deadbeef();
        test_ignore_start();
        test_reset_midframe();
        test_back_to_back();
        test_hold_start();
        checks++; if (overlap !== 1'b0)  begin errors++; $display("[TB] FAIL busy_done_overlap: got %b expected 0", overlap); end
        checks++; if (idle_low !== 1'b0) begin errors++; $display("[TB] FAIL idle_tx_high: got %b expected 0", idle_low); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
